// File: rtl/parity_frame_tx_if.sv
// Handshake and serial-line bundle for parity_frame_tx.
// The master offers words and watches the line; the slave is the transmitter.
interface parity_frame_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       tx_out;
  logic       tx_busy;
  logic       frame_done;

  modport master (output in_valid, in_data,
                  input  in_ready, tx_out, tx_busy, frame_done);
  modport slave  (input  in_valid, in_data,
                  output in_ready, tx_out, tx_busy, frame_done);
endinterface

// File: rtl/parity_frame_tx.sv
// 4-bit payload serializer: start, d0..d3 LSB first, parity, stop.
// A 2-entry FIFO in front allows gapless back-to-back frames.
module parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input logic              clk,
  input logic              rst_n,
  parity_frame_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [7:0] LAST     = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] PRE_LAST = 8'(CLKS_PER_BIT - 2);

  state_t          state;
  logic [7:0]      cnt;
  logic [1:0]      bit_idx;
  logic [3:0]      shreg;
  logic            par_q;
  logic [1:0][3:0] mem;
  logic            wr_ptr, rd_ptr;
  logic [1:0]      count, count_nxt;
  logic            in_ready_q, tx_q, done_q;
  logic            push, pop, bit_end, head_par;
  logic [3:0]      head;

  assign bit_end  = (cnt == LAST);
  assign head     = mem[rd_ptr];
  assign head_par = (^head) ^ (PARITY_ODD != 0);
  assign push     = bus.in_valid && in_ready_q;
  // Pops happen only on frame-launch edges: out of IDLE or at the end of STOP.
  assign pop      = (count != 2'd0) && ((state == IDLE) || (state == STOP && bit_end));

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 2'd1;
    else if (pop && !push) count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem        <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count      <= count_nxt;
      // Registered from next occupancy so in_valid never reaches in_ready combinationally.
      in_ready_q <= (count_nxt < 2'd2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 2'd0;
      shreg   <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // Set one edge early so the pulse lines up with the last STOP cycle.
      done_q <= (state == STOP) && (cnt == PRE_LAST);
      cnt    <= bit_end ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          cnt <= 8'd0;
          if (pop) begin
            state <= START;
            tx_q  <= 1'b0;
            shreg <= head;
            par_q <= head_par;
          end
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= 2'd0;
          tx_q    <= shreg[0];
        end
        DATA: if (bit_end) begin
          if (bit_idx == 2'd3) begin
            state <= PARITY;
            tx_q  <= par_q;
          end else begin
            bit_idx <= bit_idx + 2'd1;
            shreg   <= shreg >> 1;
            tx_q    <= shreg[1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (pop) begin
            state <= START;
            tx_q  <= 1'b0;
            shreg <= head;
            par_q <= head_par;
          end else begin
            state <= IDLE;
            tx_q  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.tx_out     = tx_q;
  assign bus.frame_done = done_q;
  assign bus.tx_busy    = (state != IDLE);
endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: an even-parity and an odd-parity instance share clock/reset;
// line activity is logged every cycle and compared against frames built from the word list.
module tb_parity_frame_tx;
  localparam int C  = 4;
  localparam int FL = 7 * C;
  localparam logic [FL-1:0] DONE_EXP = {1'b1, {(FL-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  parity_frame_tx_if b0();
  parity_frame_tx_if b1();

  parity_frame_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  parity_frame_tx #(.CLKS_PER_BIT(C), .PARITY_ODD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int   total = 0;
  int   passed = 0;
  bit   logging = 1'b0;
  logic q0[$], q1[$], dq0[$], dq1[$];

  always @(negedge clk) if (logging) begin
    q0.push_back(b0.tx_out);  dq0.push_back(b0.frame_done);
    q1.push_back(b1.tx_out);  dq1.push_back(b1.frame_done);
  end

  // Reference frame: each of the 7 symbols held C cycles; parity makes the
  // count of ones (data + parity) even, or odd in odd mode.
  function automatic logic [FL-1:0] exp_frame(input logic [3:0] d, input bit odd);
    logic [6:0]    fb;
    logic [FL-1:0] r;
    int            ones;
    ones = $countones(d);
    fb = {1'b1, 1'((ones + (odd ? 1 : 0)) % 2), d, 1'b0};
    for (int i = 0; i < FL; i++) r[i] = fb[i / C];
    return r;
  endfunction

  function automatic int first_low(input bit sel);
    if (sel) begin
      for (int i = 0; i < q1.size(); i++) if (q1[i] === 1'b0) return i;
    end else begin
      for (int i = 0; i < q0.size(); i++) if (q0[i] === 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic logic [FL-1:0] obs_line(input bit sel, input int s);
    logic [FL-1:0] r;
    r = 'x;
    for (int i = 0; i < FL; i++) begin
      if (s >= 0 && sel && (s + i) < q1.size())  r[i] = q1[s + i];
      if (s >= 0 && !sel && (s + i) < q0.size()) r[i] = q0[s + i];
    end
    return r;
  endfunction

  function automatic logic [FL-1:0] obs_done(input int s);
    logic [FL-1:0] r;
    r = 'x;
    for (int i = 0; i < FL; i++) if (s >= 0 && (s + i) < dq0.size()) r[i] = dq0[s + i];
    return r;
  endfunction

  function automatic int done_count();
    int n = 0;
    foreach (dq0[i]) if (dq0[i] === 1'b1) n++;
    return n;
  endfunction

  task automatic clear_logs();
    q0.delete(); q1.delete(); dq0.delete(); dq1.delete();
    logging = 1'b1;
  endtask

  // Offers one word once in_ready is seen high; returns just after the accepting edge.
  task automatic push_word(input bit sel, input logic [3:0] d);
    int n = 0;
    while (((sel ? b1.in_ready : b0.in_ready) !== 1'b1) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      total++;
      $display("FAIL push_timeout: in_ready=0 after %0d cycles, required 1", n);
    end
    if (sel) begin b1.in_valid = 1'b1; b1.in_data = d; end
    else     begin b0.in_valid = 1'b1; b0.in_data = d; end
    @(negedge clk);
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    b0.in_data  = 4'($urandom); b1.in_data = 4'($urandom);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({b0.tx_out, b0.tx_busy, b0.frame_done, b0.in_ready} !== 4'b1000)
      $display("FAIL reset_outputs0: got %b required 1000", {b0.tx_out, b0.tx_busy, b0.frame_done, b0.in_ready});
    else passed++;
    total++;
    if ({b1.tx_out, b1.tx_busy, b1.frame_done, b1.in_ready} !== 4'b1000)
      $display("FAIL reset_outputs1: got %b required 1000", {b1.tx_out, b1.tx_busy, b1.frame_done, b1.in_ready});
    else passed++;
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (b0.in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b required 0", b0.in_ready);
    else passed++;
    @(negedge clk);
    total++;
    if ({b0.in_ready, b1.in_ready} !== 2'b11)
      $display("FAIL ready_after_edge: got %b required 11", {b0.in_ready, b1.in_ready});
    else passed++;
  endtask

  task automatic test_single();
    logic [3:0] w[4];
    int s;
    int seq[7] = '{0, 1, 1, 0, 1, 1, 1};
    logic [FL-1:0] spec_line;
    for (int i = 0; i < FL; i++) spec_line[i] = seq[i / C][0];
    w[0] = 4'b1011;
    for (int k = 1; k < 4; k++) w[k] = 4'($urandom);
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      push_word(0, w[k]);
      total++;
      if ({b0.tx_out, b0.tx_busy} !== 2'b10)
        $display("FAIL single_pre_start w=%b: tx/busy got %b required 10", w[k], {b0.tx_out, b0.tx_busy});
      else passed++;
      @(negedge clk);
      total++;
      if ({b0.tx_out, b0.tx_busy} !== 2'b01)
        $display("FAIL single_start_latency w=%b: tx/busy got %b required 01", w[k], {b0.tx_out, b0.tx_busy});
      else passed++;
      repeat (FL + 4) @(negedge clk);
      s = first_low(0);
      total++;
      if (obs_line(0, s) !== exp_frame(w[k], 1'b0))
        $display("FAIL single_frame w=%b: line got %b required %b", w[k], obs_line(0, s), exp_frame(w[k], 1'b0));
      else passed++;
      total++;
      if (obs_done(s) !== DONE_EXP)
        $display("FAIL single_done_pos w=%b: got %b required %b", w[k], obs_done(s), DONE_EXP);
      else passed++;
      total++;
      if ({done_count(), b0.tx_busy, b0.tx_out} !== {32'd1, 2'b01})
        $display("FAIL single_end w=%b: done_count=%0d busy=%b tx=%b required 1,0,1", w[k], done_count(), b0.tx_busy, b0.tx_out);
      else passed++;
      if (k == 0) begin
        total++;
        if (obs_line(0, s) !== spec_line)
          $display("FAIL single_vector_1011: got %b required %b", obs_line(0, s), spec_line);
        else passed++;
      end
    end
  endtask

  task automatic test_odd_parity();
    logic [3:0] w[3];
    bit par_tab[2] = '{1'b1, 1'b0};
    int s;
    logic [FL-1:0] obs;
    w[0] = 4'b0000; w[1] = 4'b0001; w[2] = 4'($urandom);
    for (int k = 0; k < 3; k++) begin
      clear_logs();
      push_word(1, w[k]);
      repeat (FL + 6) @(negedge clk);
      s = first_low(1);
      obs = obs_line(1, s);
      total++;
      if (obs !== exp_frame(w[k], 1'b1))
        $display("FAIL odd_frame w=%b: got %b required %b", w[k], obs, exp_frame(w[k], 1'b1));
      else passed++;
      if (k < 2) begin
        total++;
        if (obs[5*C] !== par_tab[k])
          $display("FAIL odd_parity_bit w=%b: got %b required %b", w[k], obs[5*C], par_tab[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w[3];
    int idx = 0, cyc = 0, s;
    logic rdy;
    for (int k = 0; k < 3; k++) w[k] = 4'($urandom);
    clear_logs();
    b0.in_valid = 1'b1; b0.in_data = w[0];
    while (idx < 3 && cyc < 50) begin
      rdy = b0.in_ready;
      @(negedge clk); cyc++;
      if (rdy) begin idx++; if (idx < 3) b0.in_data = w[idx]; end
    end
    b0.in_valid = 1'b0;
    total++;
    if ({cyc, b0.in_ready} !== {32'd3, 1'b0})
      $display("FAIL b2b_accept: cycles=%0d ready=%b required 3 cycles, ready 0", cyc, b0.in_ready);
    else passed++;
    repeat (3 * FL + 6) @(negedge clk);
    s = first_low(0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_line(0, s + k * FL) !== exp_frame(w[k], 1'b0))
        $display("FAIL b2b_frame%0d: got %b required %b", k, obs_line(0, s + k * FL), exp_frame(w[k], 1'b0));
      else passed++;
      total++;
      if (obs_done(s + k * FL) !== DONE_EXP)
        $display("FAIL b2b_done%0d: got %b required %b", k, obs_done(s + k * FL), DONE_EXP);
      else passed++;
    end
    total++;
    if ({done_count(), q0[s + 3 * FL], b0.tx_busy} !== {32'd3, 2'b10})
      $display("FAIL b2b_end: done_count=%0d idle=%b busy=%b required 3,1,0", done_count(), q0[s + 3 * FL], b0.tx_busy);
    else passed++;
  endtask

  task automatic test_full_fifo();
    logic [3:0] w[3];
    int idx = 0, cyc = 0, s, ready_seen = 0, extra_lows = 0;
    logic rdy;
    for (int k = 0; k < 3; k++) w[k] = 4'($urandom);
    clear_logs();
    b0.in_valid = 1'b1; b0.in_data = w[0];
    while (idx < 3 && cyc < 50) begin
      rdy = b0.in_ready;
      @(negedge clk); cyc++;
      if (rdy) begin idx++; if (idx < 3) b0.in_data = w[idx]; end
    end
    for (int i = 0; i < 10; i++) begin
      b0.in_data = 4'($urandom);
      if (b0.in_ready === 1'b1) ready_seen++;
      @(negedge clk);
    end
    b0.in_valid = 1'b0;
    total++;
    if (ready_seen !== 0) $display("FAIL full_ready: ready high %0d times, required 0", ready_seen);
    else passed++;
    repeat (3 * FL + 20) @(negedge clk);
    s = first_low(0);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_line(0, s + k * FL) !== exp_frame(w[k], 1'b0))
        $display("FAIL full_frame%0d: got %b required %b", k, obs_line(0, s + k * FL), exp_frame(w[k], 1'b0));
      else passed++;
    end
    for (int i = s + 3 * FL; i < q0.size(); i++) if (q0[i] !== 1'b1) extra_lows++;
    total++;
    if ({extra_lows, done_count()} !== {32'd0, 32'd3})
      $display("FAIL full_no_extra: extra_lows=%0d done_count=%0d required 0,3", extra_lows, done_count());
    else passed++;
  endtask

  task automatic test_mid_reset();
    logic [3:0] w0, w1;
    int s;
    w0 = 4'($urandom); w1 = 4'($urandom);
    clear_logs();
    push_word(0, w0);
    repeat (C + 2) @(negedge clk);
    total++;
    if (b0.tx_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b required 1", b0.tx_busy);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({b0.tx_out, b0.tx_busy, b0.frame_done, b0.in_ready} !== 4'b1000)
      $display("FAIL midrst_async: got %b required 1000", {b0.tx_out, b0.tx_busy, b0.frame_done, b0.in_ready});
    else passed++;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (FL) @(negedge clk);
    total++;
    if ({done_count(), b0.tx_busy, b0.in_ready} !== {32'd0, 2'b01})
      $display("FAIL midrst_abort: done_count=%0d busy=%b ready=%b required 0,0,1", done_count(), b0.tx_busy, b0.in_ready);
    else passed++;
    clear_logs();
    push_word(0, w1);
    repeat (FL + 6) @(negedge clk);
    s = first_low(0);
    total++;
    if (obs_line(0, s) !== exp_frame(w1, 1'b0))
      $display("FAIL midrst_next_frame: got %b required %b", obs_line(0, s), exp_frame(w1, 1'b0));
    else passed++;
    total++;
    if (obs_done(s) !== DONE_EXP)
      $display("FAIL midrst_next_done: got %b required %b", obs_done(s), DONE_EXP);
    else passed++;
  endtask

  task automatic test_push_pop();
    logic [3:0] w[4];
    int s;
    for (int k = 0; k < 4; k++) w[k] = 4'($urandom);
    clear_logs();
    push_word(0, w[0]);
    push_word(0, w[1]);
    repeat (FL - 1) @(negedge clk);
    // Now in the final STOP cycle of the first frame, one word buffered.
    total++;
    if ({b0.frame_done, b0.in_ready} !== 2'b11)
      $display("FAIL pp_last_stop: done/ready got %b required 11", {b0.frame_done, b0.in_ready});
    else passed++;
    push_word(0, w[2]);
    total++;
    if (b0.in_ready !== 1'b1) $display("FAIL pp_occupancy_one: ready got %b required 1", b0.in_ready);
    else passed++;
    push_word(0, w[3]);
    total++;
    if (b0.in_ready !== 1'b0) $display("FAIL pp_occupancy_two: ready got %b required 0", b0.in_ready);
    else passed++;
    repeat (4 * FL + 6) @(negedge clk);
    s = first_low(0);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (obs_line(0, s + k * FL) !== exp_frame(w[k], 1'b0))
        $display("FAIL pp_frame%0d: got %b required %b", k, obs_line(0, s + k * FL), exp_frame(w[k], 1'b0));
      else passed++;
    end
    total++;
    if (done_count() !== 4) $display("FAIL pp_done_count: got %0d required 4", done_count());
    else passed++;
  endtask

  initial begin
    b0.in_valid = 1'b0; b0.in_data = 4'd0;
    b1.in_valid = 1'b0; b1.in_data = 4'd0;
    test_reset();
    test_single();
    test_odd_parity();
    test_back_to_back();
    test_full_fifo();
    test_mid_reset();
    test_push_pop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/parity_frame_tx.md
PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period (legal range 2..255).
REQ-002 SHALL provide parameter PARITY_ODD, default 0, meaning parity mode: 0 = even parity, 1 = odd parity (XNOR form).
REQ-003 SHALL provide port clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port in_valid  input  1  a payload word is offered.
REQ-006 SHALL provide port in_ready  output  1  the block can accept a word this cycle.
REQ-007 SHALL provide port in_data  input  4  payload bits d0..d3.
REQ-008 SHALL provide port tx_out  output  1  serial line, registered, idle high.
REQ-009 SHALL provide port tx_busy  output  1  a frame is being shifted out.
REQ-010 SHALL provide port frame_done  output  1  single-cycle pulse when a frame completes.

Function
REQ-011 SHALL accept a word on any rising edge where in_valid and in_ready are both 1, writing it into a 2-entry FIFO.
REQ-012 SHALL drive in_ready = 1 exactly when the FIFO holds fewer than 2 entries, based on registered state, with no combinational path from in_valid.
REQ-013 SHALL send each frame as 7 bits: start (0), d0, d1, d2, d3 (LSB first), parity, stop (1), each bit held for CLKS_PER_BIT cycles.
REQ-014 SHALL compute parity = XOR(d0..d3) when PARITY_ODD = 0, and parity = XNOR(d0..d3) when PARITY_ODD = 1, latched when the word is popped.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL transition IDLE->START on the edge after the FIFO becomes non-empty, popping the head entry on that edge.
REQ-017 SHALL transition START->DATA, DATA->PARITY (after the 4th data bit) and PARITY->STOP when the bit counter reaches CLKS_PER_BIT-1.
REQ-018 SHALL, at the end of STOP, go to START and pop the next word in the same edge if the FIFO is non-empty, giving a gapless frame; otherwise it SHALL go to IDLE.
REQ-019 SHALL make tx_out first go low one edge after the accepting edge when the FSM is idle and the FIFO is empty.
REQ-020 SHALL pulse frame_done high for exactly the final cycle of the STOP bit.
REQ-021 SHALL drive tx_busy = 1 in every state except IDLE.
REQ-022 SHALL perform a push and a pop in the same edge when the FIFO holds 1 entry and a word is accepted at an end-of-STOP or IDLE->START edge, leaving the occupancy unchanged.
REQ-023 SHALL leave FIFO contents and pointers untouched when in_valid = 1 and in_ready = 0 (the offered word is not accepted).
REQ-024 SHALL ignore in_data whenever in_valid = 0.
REQ-025 SHALL wrap the FIFO read and write pointers modulo 2 without loss or duplication of words.
REQ-026 SHALL have a total frame duration of 7*CLKS_PER_BIT cycles, from the first low cycle of start to the last cycle of stop.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force tx_out = 1, tx_busy = 0, frame_done = 0, in_ready = 0, FSM = IDLE, FIFO empty and counters = 0.
REQ-028 SHALL abort any frame in progress on reset assertion, with no partial frame completed and no frame_done pulse.
REQ-029 SHALL raise in_ready to 1 on the first rising edge after rst_n deasserts.

Verification
REQ-030 Single word: CLKS_PER_BIT = 4, PARITY_ODD = 0, push 4'b1011 -> tx_out sequence 0,1,1,0,1,1,1 (each bit 4 cycles), frame_done once at cycle 28 of the frame.
REQ-031 Odd parity: PARITY_ODD = 1, push 4'b0000 -> parity bit = 1; push 4'b0001 -> parity bit = 0.
REQ-032 Back-to-back: push 3 words on consecutive cycles -> in_ready drops to 0 after 2 are buffered, 3 gapless frames are sent (84 cycles at CLKS_PER_BIT = 4), 3 frame_done pulses.
REQ-033 Full FIFO: hold in_valid = 1 with in_ready = 0 for 10 cycles while changing in_data -> no extra word is transmitted and frame order is preserved.
REQ-034 Mid-frame reset: assert rst_n = 0 during the DATA state -> tx_out = 1 immediately, no frame_done, and the next pushed word is sent as a complete, correct frame.
REQ-035 Simultaneous push and pop: push a word exactly on the end-of-STOP edge with 1 entry buffered -> both words are transmitted in order and occupancy stays at 1.
